hazard_track: RTL and testbench

Destination-register tracking and load-use hazard unit for the MISC-V pipeline. Sits in the ID stage: it shifts each issued instruction's destination register through EX, MEM and WB slots, supplies `rdMEM`/`rdWB` (with valid bits) to the forwarding unit, and detects load-use hazards, stalling ID and inserting EX bubbles. It also honours an external memory hold, branch flush, and keeps a saturating stall-cycle counter.

---
 rtl/hazard_track.sv | 129 ++++++++++++
 tb/tb_hazard_track.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_track.sv
// ============================================================================
//  Module   : hazard_track
//  Brief    : Destination-register tracking through EX/MEM/WB, load-use hazard
//             detection with stall/bubble generation, memory-hold freeze,
//             branch-flush squash (deferred across hold) and a saturating
//             stall-cycle counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_track #(
    parameter int REG_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic [REG_W-1:0] rd,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             hold,
    input  logic             flush,
    output logic [REG_W-1:0] rdEX,
    output logic [REG_W-1:0] rdMEM,
    output logic [REG_W-1:0] rdWB,
    output logic             vEX,
    output logic             vMEM,
    output logic             vWB,
    output logic             stall,
    output logic             bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [REG_W-1:0] c_ZERO_REG = '0;
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    // Slot state
    logic [REG_W-1:0] r_ex_rd;
    logic             r_ex_v;
    logic             r_ex_ld;
    logic [REG_W-1:0] r_mem_rd;
    logic             r_mem_v;
    logic [REG_W-1:0] r_wb_rd;
    logic             r_wb_v;
    logic             r_flush_pend;
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_rs1_hit;
    logic             w_rs2_hit;
    logic             w_load_use;
    logic             w_flush_eff;
    logic             w_stall;
    logic             w_bubble;
    logic             w_id_writes;

    // Hazard detection: a source of x0 never matches since x0 is not tracked
    always_comb begin
        w_rs1_hit   = use_rs1 && (rs1 != c_ZERO_REG) && (rs1 == r_ex_rd);
        w_rs2_hit   = use_rs2 && (rs2 != c_ZERO_REG) && (rs2 == r_ex_rd);
        w_load_use  = r_ex_v && r_ex_ld && (w_rs1_hit || w_rs2_hit);
        w_flush_eff = flush || r_flush_pend;
        // A squashed consumer needs no stall, so flush masks load-use here
        w_stall     = hold || (w_load_use && !w_flush_eff);
        w_bubble    = !hold && (w_load_use || w_flush_eff);
        w_id_writes = reg_write && (rd != c_ZERO_REG);
    end

    // Slot shift register and deferred flush; hold freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_rd      <= '0;
            r_ex_v       <= 1'b0;
            r_ex_ld      <= 1'b0;
            r_mem_rd     <= '0;
            r_mem_v      <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_v       <= 1'b0;
            r_flush_pend <= 1'b0;
        end else if (hold) begin
            if (flush) begin
                r_flush_pend <= 1'b1;
            end
        end else begin
            r_wb_rd      <= r_mem_rd;
            r_wb_v       <= r_mem_v;
            r_mem_rd     <= r_ex_rd;
            r_mem_v      <= r_ex_v;
            r_flush_pend <= 1'b0;
            if (w_bubble) begin
                r_ex_rd <= '0;
                r_ex_v  <= 1'b0;
                r_ex_ld <= 1'b0;
            end else begin
                // Non-writing instructions keep a zero rd so slot compares stay clean
                r_ex_rd <= w_id_writes ? rd : c_ZERO_REG;
                r_ex_v  <= w_id_writes;
                r_ex_ld <= mem_read;
            end
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Forwarding-facing views: invalid slots read as x0
    always_comb begin
        rdEX      = r_ex_v  ? r_ex_rd  : c_ZERO_REG;
        rdMEM     = r_mem_v ? r_mem_rd : c_ZERO_REG;
        rdWB      = r_wb_v  ? r_wb_rd  : c_ZERO_REG;
        vEX       = r_ex_v;
        vMEM      = r_mem_v;
        vWB       = r_wb_v;
        stall     = w_stall;
        bubble    = w_bubble;
        stall_cnt = r_stall_cnt;
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_track.sv
// ============================================================================
//  Module   : tb_hazard_track
//  Brief    : Directed self-checking bench for hazard_track.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_track;

    localparam int REG_W = 3;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic [REG_W-1:0] rs1, rs2, rd;
    logic             use_rs1, use_rs2, reg_write, mem_read, hold, flush;
    logic [REG_W-1:0] rdEX, rdMEM, rdWB;
    logic             vEX, vMEM, vWB, stall, bubble;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    hazard_track #(.REG_W(REG_W), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .rs1       (rs1),
        .rs2       (rs2),
        .use_rs1   (use_rs1),
        .use_rs2   (use_rs2),
        .rd        (rd),
        .reg_write (reg_write),
        .mem_read  (mem_read),
        .hold      (hold),
        .flush     (flush),
        .rdEX      (rdEX),
        .rdMEM     (rdMEM),
        .rdWB      (rdWB),
        .vEX       (vEX),
        .vMEM      (vMEM),
        .vWB       (vWB),
        .stall     (stall),
        .bubble    (bubble),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        rs1 = '0; rs2 = '0; rd = '0;
        use_rs1 = 1'b0; use_rs2 = 1'b0;
        reg_write = 1'b0; mem_read = 1'b0;
        flush = 1'b0;
    endtask

    task automatic issue(input logic [REG_W-1:0] d, input logic w, input logic ld);
        rd = d; reg_write = w; mem_read = ld;
    endtask

    initial begin
        clear_id();
        hold = 1'b0;
        rst  = 1'b1;
        tick(); tick();

        // ---------------- reset state ----------------
        check("rst_vEX", vEX, 0);
        check("rst_rdWB", rdWB, 0);
        check("rst_stall", stall, 0);
        check("rst_bubble", bubble, 0);
        check("rst_cnt", stall_cnt, 0);
        rst = 1'b0;
        #1;

        // ---------------- pipeline shift ----------------
        issue(3, 1, 0); tick();
        issue(5, 1, 0); tick();
        issue(0, 1, 0); tick();
        clear_id(); #1;
        check("shift_rdWB", rdWB, 3);
        check("shift_vWB", vWB, 1);
        check("shift_rdMEM", rdMEM, 5);
        check("shift_vMEM", vMEM, 1);
        check("shift_rdEX", rdEX, 0);
        check("shift_vEX", vEX, 0);

        // ---------------- load-use ----------------
        issue(2, 1, 1); tick();
        check("lu_load_in_ex", rdEX, 2);
        rs1 = 2; use_rs1 = 1'b1; issue(4, 1, 0); #1;
        check("lu_stall", stall, 1);
        check("lu_bubble", bubble, 1);
        tick();
        check("lu_ex_bubble", vEX, 0);
        check("lu_rdEX_zero", rdEX, 0);
        check("lu_rdMEM", rdMEM, 2);
        check("lu_stall_drop", stall, 0);
        check("lu_bubble_drop", bubble, 0);
        check("lu_cnt", stall_cnt, 1);
        tick();
        check("lu_consumer_ex", rdEX, 4);
        check("lu_consumer_v", vEX, 1);
        check("lu_load_wb", rdWB, 2);
        clear_id(); #1;

        // ---------------- flush beats load-use ----------------
        issue(6, 1, 1); tick();
        rs2 = 6; use_rs2 = 1'b1; issue(1, 1, 0); flush = 1'b1; #1;
        check("fl_stall", stall, 0);
        check("fl_bubble", bubble, 1);
        tick();
        check("fl_ex_squashed", vEX, 0);
        check("fl_cnt", stall_cnt, 1);
        clear_id(); #1;

        // ---------------- second load to a different register ----------------
        issue(7, 1, 1); tick();
        rs1 = 7; use_rs1 = 1'b1; issue(3, 1, 1); #1;
        check("ll_stall1", stall, 1);
        tick();
        check("ll_cnt1", stall_cnt, 2);
        check("ll_stall1_drop", stall, 0);
        tick();
        check("ll_load2_ex", rdEX, 3);
        rs1 = 0; use_rs1 = 1'b0; rs2 = 3; use_rs2 = 1'b1; issue(5, 1, 0); #1;
        check("ll_stall2", stall, 1);
        tick();
        check("ll_cnt2", stall_cnt, 3);
        clear_id(); #1;
        // Pipeline now: EX=bubble, MEM=3, WB=bubble

        // ---------------- hold with pending flush ----------------
        issue(1, 1, 0); tick();          // EX=1, MEM=0, WB=3
        issue(2, 1, 0); hold = 1'b1; #1;
        check("hd_stall", stall, 1);
        check("hd_bubble", bubble, 0);
        tick();
        flush = 1'b1; #1;
        check("hd_bubble_flush", bubble, 0);
        tick();
        flush = 1'b0; #1;
        tick();
        check("hd_frozen_ex", rdEX, 1);
        check("hd_frozen_wb", rdWB, 3);
        check("hd_cnt", stall_cnt, 6);
        hold = 1'b0; #1;
        check("hd_pend_bubble", bubble, 1);
        check("hd_pend_stall", stall, 0);
        tick();
        check("hd_ex_squashed", vEX, 0);
        check("hd_mem", rdMEM, 1);
        check("hd_pend_clear", bubble, 0);
        check("hd_cnt_after", stall_cnt, 6);

        // ---------------- asynchronous reset mid-operation ----------------
        hold = 1'b1; flush = 1'b1; tick();   // flush_pend set, cnt=7
        flush = 1'b0; #1;
        check("ar_cnt_before", stall_cnt, 7);
        #2 rst = 1'b1; #1;
        check("ar_vMEM", vMEM, 0);
        check("ar_rdMEM", rdMEM, 0);
        check("ar_cnt", stall_cnt, 0);
        hold = 1'b0; #1;
        check("ar_pend_gone", bubble, 0);
        tick();
        rst = 1'b0; #1;

        // ---------------- counter saturation ----------------
        hold = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        check("sat_cnt", stall_cnt, 255);
        for (int i = 0; i < 5; i++) tick();
        check("sat_cnt_stays", stall_cnt, 255);
        hold = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
